// File: rtl/neuron_mac_seq.sv
// Pipelined multi-beat MAC neuron: LANES products per beat, accumulated over BEATS
// beats plus bias, then optional ReLU and signed saturation to OUT_W.
module neuron_mac_seq #(
  parameter int IN_W  = 12,
  parameter int W_W   = 5,
  parameter int LANES = 4,
  parameter int BEATS = 1,
  parameter int OUT_W = 17,
  parameter int ACC_W = IN_W + W_W + $clog2(LANES * BEATS) + 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES*IN_W-1:0]   in_data_i,
  input  logic [LANES*W_W-1:0]    in_weight_i,
  input  logic [OUT_W-1:0]        bias_i,
  input  logic                    relu_en_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [OUT_W-1:0]        out_data_o,
  output logic                    out_sat_o
);

  localparam int PW = IN_W + W_W;
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {ST_ACCUM, ST_WAIT, ST_HOLD} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           beat_cnt_q, beat_cnt_d;
  logic                    accept, first_beat, last_beat;

  logic signed [PW-1:0]    prod_d [LANES];
  logic signed [PW-1:0]    prod_q [LANES];
  logic                    p_valid_q, p_first_q, p_last_q, p_relu_q;
  logic [OUT_W-1:0]        p_bias_q;

  logic signed [ACC_W-1:0] acc_q, acc_in, lane_sum, sum_v, relu_v;
  logic [OUT_W-1:0]        clip_v;
  logic                    sat_v;
  logic                    out_valid_q, out_sat_q;
  logic [OUT_W-1:0]        out_data_q;

  assign in_ready_o = (state_q == ST_ACCUM);
  assign accept     = in_valid_i && in_ready_o;
  assign first_beat = (beat_cnt_q == '0);
  assign last_beat  = (beat_cnt_q == CW'(BEATS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_ACCUM;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    if (accept) beat_cnt_d = last_beat ? '0 : beat_cnt_q + CW'(1);
    unique case (state_q)
      ST_ACCUM: if (accept && last_beat) state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_HOLD;
      ST_HOLD:  if (out_ready_i) state_d = ST_ACCUM;
      default:  state_d = ST_ACCUM;
    endcase
  end

  // Operands are sign-extended to PW so the product keeps full precision.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = $signed({{W_W{in_data_i[i*IN_W+IN_W-1]}}, in_data_i[i*IN_W +: IN_W]}) *
                  $signed({{IN_W{in_weight_i[i*W_W+W_W-1]}}, in_weight_i[i*W_W +: W_W]});
    end
  end

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + {{(ACC_W-PW){prod_q[i][PW-1]}}, prod_q[i]};
    end
    acc_in = p_first_q ? {{(ACC_W-OUT_W){p_bias_q[OUT_W-1]}}, p_bias_q} : acc_q;
    sum_v  = acc_in + lane_sum;
    relu_v = (p_relu_q && sum_v[ACC_W-1]) ? '0 : sum_v;
    clip_v = relu_v[OUT_W-1:0];
    sat_v  = 1'b0;
    if (relu_v > MAX_V) begin
      clip_v = MAX_V[OUT_W-1:0];
      sat_v  = 1'b1;
    end else if (relu_v < MIN_V) begin
      clip_v = MIN_V[OUT_W-1:0];
      sat_v  = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      p_valid_q   <= 1'b0;
      p_first_q   <= 1'b0;
      p_last_q    <= 1'b0;
      p_relu_q    <= 1'b0;
      p_bias_q    <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      p_valid_q <= accept;
      if (accept) begin
        prod_q    <= prod_d;
        p_first_q <= first_beat;
        p_last_q  <= last_beat;
        // bias and relu_en belong to the whole result, so only the first beat loads them
        if (first_beat) begin
          p_bias_q <= bias_i;
          p_relu_q <= relu_en_i;
        end
      end
      if (p_valid_q) acc_q <= sum_v;
      if (p_valid_q && p_last_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= clip_v;
        out_sat_q   <= sat_v;
      end else if (out_valid_q && out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_sat_o   = out_sat_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Directed + randomized bench for neuron_mac_seq: a single-beat instance (A) and a
// three-beat instance (B), checked against a plain-arithmetic reference model.
module tb_neuron_mac_seq;
  localparam int IN_W = 12;
  localparam int W_W = 5;
  localparam int LANES = 4;
  localparam int OUT_W = 17;
  localparam longint MAXO = (longint'(1) <<< (OUT_W - 1)) - 1;
  localparam longint MINO = -(longint'(1) <<< (OUT_W - 1));

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic                  a_rst, a_in_valid, a_in_ready, a_relu, a_out_valid, a_out_ready, a_out_sat;
  logic [LANES*IN_W-1:0] a_in_data;
  logic [LANES*W_W-1:0]  a_in_weight;
  logic [OUT_W-1:0]      a_bias, a_out_data;
  logic                  b_rst, b_in_valid, b_in_ready, b_relu, b_out_valid, b_out_ready, b_out_sat;
  logic [LANES*IN_W-1:0] b_in_data;
  logic [LANES*W_W-1:0]  b_in_weight;
  logic [OUT_W-1:0]      b_bias, b_out_data;

  neuron_mac_seq #(.IN_W(IN_W), .W_W(W_W), .LANES(LANES), .BEATS(1), .OUT_W(OUT_W)) u_a (
    .clk_i(clk), .rst_i(a_rst), .in_valid_i(a_in_valid), .in_ready_o(a_in_ready),
    .in_data_i(a_in_data), .in_weight_i(a_in_weight), .bias_i(a_bias), .relu_en_i(a_relu),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
    .out_sat_o(a_out_sat));

  neuron_mac_seq #(.IN_W(IN_W), .W_W(W_W), .LANES(LANES), .BEATS(3), .OUT_W(OUT_W)) u_b (
    .clk_i(clk), .rst_i(b_rst), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready),
    .in_data_i(b_in_data), .in_weight_i(b_in_weight), .bias_i(b_bias), .relu_en_i(b_relu),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
    .out_sat_o(b_out_sat));

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANES*IN_W-1:0] pack_x(input int v[4]);
    logic [LANES*IN_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*IN_W +: IN_W] = IN_W'(v[i]);
    return r;
  endfunction

  function automatic logic [LANES*W_W-1:0] pack_w(input int v[4]);
    logic [LANES*W_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*W_W +: W_W] = W_W'(v[i]);
    return r;
  endfunction

  function automatic longint dot(input int x[4], input int w[4]);
    longint s = 0;
    for (int i = 0; i < LANES; i++) s += longint'(x[i]) * longint'(w[i]);
    return s;
  endfunction

  function automatic void ref_out(input longint total, input bit relu, output longint res,
                                  output bit sat);
    longint v = total;
    if (relu && v < 0) v = 0;
    sat = 1'b0;
    if (v > MAXO) begin v = MAXO; sat = 1'b1; end
    else if (v < MINO) begin v = MINO; sat = 1'b1; end
    res = v;
  endfunction

  function automatic void rand_vec(output int x[4], output int w[4]);
    for (int i = 0; i < LANES; i++) begin
      x[i] = int'($urandom_range(0, 4095)) - 2048;
      w[i] = int'($urandom_range(0, 31)) - 16;
    end
  endfunction

  task automatic a_apply(input int x[4], input int w[4], input int bias, input bit relu);
    for (int k = 0; k < 10 && !a_in_ready; k++) tick();
    check("a_ready_wait", a_in_ready, 1);
    a_in_data = pack_x(x); a_in_weight = pack_w(w);
    a_bias = OUT_W'(bias); a_relu = relu; a_in_valid = 1'b1;
    tick();
    a_in_valid = 1'b0;
  endtask

  task automatic b_apply(input int x[4], input int w[4], input int bias, input bit relu);
    for (int k = 0; k < 10 && !b_in_ready; k++) tick();
    check("b_ready_wait", b_in_ready, 1);
    b_in_data = pack_x(x); b_in_weight = pack_w(w);
    b_bias = OUT_W'(bias); b_relu = relu; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic a_expect(input string tag, input longint exp, input bit exp_sat);
    check({tag, "_valid"}, a_out_valid, 1);
    check({tag, "_data"}, longint'($signed(a_out_data)), exp);
    check({tag, "_sat"}, a_out_sat, longint'(exp_sat));
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    check({tag, "_drop"}, a_out_valid, 0);
    check({tag, "_ready_back"}, a_in_ready, 1);
  endtask

  task automatic b_expect(input string tag, input longint exp, input bit exp_sat);
    check({tag, "_valid"}, b_out_valid, 1);
    check({tag, "_data"}, longint'($signed(b_out_data)), exp);
    check({tag, "_sat"}, b_out_sat, longint'(exp_sat));
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    check({tag, "_drop"}, b_out_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int x[4], w[4];
    longint r, total, exp_hold;
    bit s;
    int bias;
    bit relu;
    longint exp_q[$];
    bit sat_q[$];
    int sent, got, last_cyc;
    int sx[3][4];
    int sw[3][4];
    int sat_w[3];
    int sat_x[3];
    longint sat_exp[3];

    a_rst = 1'b1; b_rst = 1'b1;
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    a_in_data = '0; a_in_weight = '0; a_bias = '0; a_relu = 1'b0;
    b_in_data = '0; b_in_weight = '0; b_bias = '0; b_relu = 1'b0;
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0;
    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_data", a_out_data, 0);
    check("rst_a_sat", a_out_sat, 0);
    check("rst_a_ready", a_in_ready, 1);
    check("rst_b_valid", b_out_valid, 0);
    check("rst_b_ready", b_in_ready, 1);

    // basic single beat, latency of two edges
    x = '{100, 200, -50, 7}; w = '{3, -2, 5, 15};
    a_apply(x, w, 0, 1'b0);
    check("basic_e1_valid", a_out_valid, 0);
    check("basic_wait_ready", a_in_ready, 0);
    tick();
    ref_out(dot(x, w), 1'b0, r, s);
    check("basic_model", r, -245);
    a_expect("basic", -245, 1'b0);
    a_apply(x, w, 0, 1'b1);
    tick();
    a_expect("basic_relu", 0, 1'b0);

    // saturation corners
    sat_x = '{2047, -2048, -2048};
    sat_w = '{15, 15, -16};
    sat_exp = '{65535, -65536, 65535};
    for (int c = 0; c < 3; c++) begin
      x = '{sat_x[c], sat_x[c], sat_x[c], sat_x[c]};
      w = '{sat_w[c], sat_w[c], sat_w[c], sat_w[c]};
      a_apply(x, w, 0, 1'b0);
      tick();
      a_expect($sformatf("sat%0d", c), sat_exp[c], 1'b1);
    end

    // backpressure: result held for 5 cycles, then a back-to-back result
    rand_vec(x, w);
    bias = int'($urandom_range(0, 2000)) - 1000;
    a_apply(x, w, bias, 1'b0);
    tick();
    ref_out(dot(x, w) + bias, 1'b0, exp_hold, s);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", a_out_valid, 1);
      check("bp_data", longint'($signed(a_out_data)), exp_hold);
      check("bp_in_ready", a_in_ready, 0);
      tick();
    end
    a_out_ready = 1'b1;
    tick();
    a_out_ready = 1'b0;
    check("bp_drop", a_out_valid, 0);
    check("bp_ready_back", a_in_ready, 1);
    rand_vec(x, w);
    a_apply(x, w, -300, 1'b1);
    tick();
    ref_out(dot(x, w) - 300, 1'b1, r, s);
    a_expect("bp_second", r, s);

    // streaming, out_ready tied high
    a_out_ready = 1'b1;
    sent = 0; got = 0; last_cyc = 0;
    for (int t = 0; t < 60 && got < 10; t++) begin
      if (a_out_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", a_out_valid, 0);
        end else begin
          check("stream_data", longint'($signed(a_out_data)), exp_q.pop_front());
          check("stream_sat", a_out_sat, longint'(sat_q.pop_front()));
        end
        if (got > 0) check("stream_spacing", cyc - last_cyc, 3);
        last_cyc = cyc;
        got++;
      end
      if (a_in_ready && sent < 10) begin
        rand_vec(x, w);
        if (sent == 0) begin x = '{-2048, -2048, -2048, -2048}; w = '{-16, -16, -16, -16}; end
        bias = int'($urandom_range(0, 131071)) - 65536;
        relu = 1'($urandom_range(0, 1));
        a_in_data = pack_x(x); a_in_weight = pack_w(w);
        a_bias = OUT_W'(bias); a_relu = relu; a_in_valid = 1'b1;
        ref_out(dot(x, w) + bias, relu, r, s);
        exp_q.push_back(r); sat_q.push_back(s);
        sent++;
      end else begin
        a_in_valid = 1'b0;
      end
      tick();
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b0;
    check("stream_count", got, 10);

    // multi-beat with a gap and ignored bias changes on later beats
    x = '{1, 2, 3, 4}; w = '{1, 1, 1, 1};
    b_apply(x, w, -10, 1'b0);
    check("mb_mid_ready", b_in_ready, 1);
    check("mb_mid_valid", b_out_valid, 0);
    tick();
    b_apply(x, w, 500, 1'b0);
    b_apply(x, w, 500, 1'b0);
    check("mb_e1_valid", b_out_valid, 0);
    tick();
    b_expect("mb", 20, 1'b0);

    // reset after two beats discards the partial result
    rand_vec(x, w);
    b_apply(x, w, 1000, 1'b0);
    b_apply(x, w, 1000, 1'b0);
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    check("rst_mid_valid", b_out_valid, 0);
    check("rst_mid_ready", b_in_ready, 1);
    tick(); tick();
    check("rst_mid_no_out", b_out_valid, 0);
    total = 7;
    for (int bt = 0; bt < 3; bt++) begin
      rand_vec(x, w);
      sx[bt] = x; sw[bt] = w;
      total += dot(sx[bt], sw[bt]);
      b_apply(x, w, (bt == 0) ? 7 : -4000, 1'b0);
    end
    tick();
    ref_out(total, 1'b0, r, s);
    b_expect("rst_next", r, s);

    // reset while holding a result
    for (int bt = 0; bt < 3; bt++) begin
      rand_vec(x, w);
      b_apply(x, w, 12345, 1'b0);
    end
    tick();
    check("hold_valid", b_out_valid, 1);
    b_rst = 1'b1;
    tick();
    b_rst = 1'b0;
    check("rst_hold_valid", b_out_valid, 0);
    check("rst_hold_data", b_out_data, 0);
    check("rst_hold_ready", b_in_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
